// File: rtl/tt_seq_pkg.sv
// Shared types and helpers for the melody sequencer that drives the 7-tone divider.
package tt_seq_pkg;

    localparam int NUM_NOTES = 7;
    localparam int NOTE_W    = 3;
    localparam int STEPS     = 16;
    localparam int ADDR_W    = $clog2(STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2
    } state_e;

    // Code 0 is a rest (all lines low); code k selects divider line k-1.
    function automatic logic [NUM_NOTES-1:0] note_to_onehot(input logic [NOTE_W-1:0] code);
        logic [NUM_NOTES-1:0] sel;
        sel = '0;
        if (code != '0) begin
            sel = NUM_NOTES'(1) << (code - NOTE_W'(1));
        end
        return sel;
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Control, melody-load and status signals between the sequencer and its host.
interface note_sequencer_if;
    import tt_seq_pkg::*;

    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [NOTE_W-1:0]     wr_data;
    logic                  start;
    logic                  stop;
    logic                  loop_en;
    logic [7:0]            tempo;
    logic [ADDR_W-1:0]     len;
    logic [NUM_NOTES-1:0]  note_sel;
    logic [ADDR_W-1:0]     step;
    logic                  busy;
    logic                  done;

    modport master (
        output wr_en, wr_addr, wr_data, start, stop, loop_en, tempo, len,
        input  note_sel, step, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, stop, loop_en, tempo, len,
        output note_sel, step, busy, done
    );

endinterface

// File: rtl/note_sequencer_prescaler.sv
// Tick generator: one tick every PRESC enabled cycles, held at zero while cleared.
module tick_prescaler #(
    parameter int PRESC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = (PRESC > 2) ? $clog2(PRESC) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_top;

    assign at_top = (cnt_q == CW'(PRESC - 1));
    assign tick_o = en_i && !clr_i && at_top;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_top ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Melody sequencer: plays up to 16 stored note codes with per-note duration and a
// one-tick silent gap, in one-shot or looped mode.
//
//   state | meaning
//   IDLE  | stopped, outputs silent, waiting for start
//   NOTE  | sounding mem[step] for tempo_q+1 ticks
//   GAP   | silent articulation gap of one tick, then next step / loop / done
module note_sequencer
    import tt_seq_pkg::*;
#(
    parameter int PRESC = 4
) (
    input  logic             clk,
    input  logic             rst,
    note_sequencer_if.slave  bus
);

    logic [NOTE_W-1:0]     mem_q [STEPS];

    state_e                state_q;
    logic [ADDR_W-1:0]     step_q;
    logic [NUM_NOTES-1:0]  note_sel_q;
    logic                  busy_q;
    logic                  done_q;
    logic [7:0]            beat_q;
    logic [7:0]            tempo_q;
    logic [ADDR_W-1:0]     len_q;

    logic                  tick;
    logic [ADDR_W-1:0]     step_d;
    logic [NUM_NOTES-1:0]  next_sel_d;
    logic [NUM_NOTES-1:0]  first_sel_d;

    tick_prescaler #(
        .PRESC (PRESC)
    ) u_presc (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q != IDLE),
        .clr_i  (state_q == IDLE),
        .tick_o (tick)
    );

    // Reads happen before the write on the same edge lands, so a step entered
    // while its slot is being rewritten plays the old code.
    always_comb begin
        step_d      = step_q + ADDR_W'(1);
        next_sel_d  = note_to_onehot(mem_q[step_d]);
        first_sel_d = note_to_onehot(mem_q[0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STEPS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus.wr_en) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            step_q     <= '0;
            note_sel_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            beat_q     <= '0;
            tempo_q    <= '0;
            len_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_q    <= NOTE;
                        step_q     <= '0;
                        note_sel_q <= first_sel_d;
                        busy_q     <= 1'b1;
                        beat_q     <= bus.tempo;
                        tempo_q    <= bus.tempo;
                        len_q      <= bus.len;
                    end
                end
                NOTE: begin
                    if (bus.stop) begin
                        state_q    <= IDLE;
                        step_q     <= '0;
                        note_sel_q <= '0;
                        busy_q     <= 1'b0;
                    end else if (tick) begin
                        if (beat_q == '0) begin
                            state_q    <= GAP;
                            note_sel_q <= '0;
                        end else begin
                            beat_q <= beat_q - 8'd1;
                        end
                    end
                end
                GAP: begin
                    if (bus.stop) begin
                        state_q    <= IDLE;
                        step_q     <= '0;
                        note_sel_q <= '0;
                        busy_q     <= 1'b0;
                    end else if (tick) begin
                        beat_q <= tempo_q;
                        if (step_q != len_q) begin
                            state_q    <= NOTE;
                            step_q     <= step_d;
                            note_sel_q <= next_sel_d;
                        end else if (bus.loop_en) begin
                            state_q    <= NOTE;
                            step_q     <= '0;
                            note_sel_q <= first_sel_d;
                        end else begin
                            state_q    <= IDLE;
                            step_q     <= '0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    step_q     <= '0;
                    note_sel_q <= '0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.note_sel = note_sel_q;
    assign bus.step     = step_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench: each stimulus step queues the per-cycle outputs it should produce,
// then the queue is drained one clock at a time against the sequencer outputs.
module tb_note_sequencer;

    typedef struct packed {
        logic [6:0] ns;
        logic       busy;
        logic       done;
        logic [3:0] step;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    note_sequencer_if bus();

    note_sequencer #(.PRESC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [6:0] ns, input logic busy, input logic done,
                        input logic [3:0] step, input int n);
        exp_t e;
        e.ns = ns; e.busy = busy; e.done = done; e.step = step;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    // Compare the current outputs against the queue head, then advance one clock.
    task automatic drain(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL scoreboard_empty cyc %0d", cyc);
                return;
            end
            e = sb.pop_front();
            checks++;
            assert (bus.note_sel === e.ns) else begin
                errors++;
                $error("FAIL note_sel cyc %0d got %h exp %h", cyc, bus.note_sel, e.ns);
            end
            checks++;
            assert (bus.busy === e.busy) else begin
                errors++;
                $error("FAIL busy cyc %0d got %b exp %b", cyc, bus.busy, e.busy);
            end
            checks++;
            assert (bus.done === e.done) else begin
                errors++;
                $error("FAIL done cyc %0d got %b exp %b", cyc, bus.done, e.done);
            end
            checks++;
            assert (bus.step === e.step) else begin
                errors++;
                $error("FAIL step cyc %0d got %0d exp %0d", cyc, bus.step, e.step);
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic drain_all();
        drain(sb.size());
    endtask

    task automatic wr(input logic [3:0] a, input logic [2:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0;
        bus.tempo = '0; bus.len = '0;
        @(posedge clk); #1;

        // Reset state, then 20 idle cycles with start low
        push(7'h00, 0, 0, 0, 1); drain_all();
        rst = 1'b0;
        push(7'h00, 0, 0, 0, 20); drain_all();

        // One-shot: codes 1,4,7, tempo 1 -> 8-cycle notes, 4-cycle gaps
        wr(0, 3'd1); wr(1, 3'd4); wr(2, 3'd7);
        bus.tempo = 8'd1; bus.len = 4'd2; bus.loop_en = 1'b0;
        pulse_start();
        push(7'h01, 1, 0, 0, 8); push(7'h00, 1, 0, 0, 4);
        push(7'h08, 1, 0, 1, 8); push(7'h00, 1, 0, 1, 4);
        push(7'h40, 1, 0, 2, 8); push(7'h00, 1, 0, 2, 4);
        push(7'h00, 0, 1, 0, 1); push(7'h00, 0, 0, 0, 2);
        drain_all();

        // Rest + loop with tempo 0
        wr(0, 3'd0); wr(1, 3'd2);
        bus.tempo = 8'd0; bus.len = 4'd1; bus.loop_en = 1'b1;
        pulse_start();
        for (int p = 0; p < 3; p++) begin
            push(7'h00, 1, 0, 0, 8);
            push(7'h02, 1, 0, 1, 4); push(7'h00, 1, 0, 1, 4);
        end
        drain_all();
        bus.stop = 1'b1;
        push(7'h00, 1, 0, 0, 1); drain_all();
        bus.stop = 1'b0;
        push(7'h00, 0, 0, 0, 2); drain_all();

        // Abort at the 5th cycle of a note
        wr(0, 3'd3);
        bus.tempo = 8'd3; bus.len = 4'd0; bus.loop_en = 1'b0;
        pulse_start();
        push(7'h04, 1, 0, 0, 4); drain_all();
        bus.stop = 1'b1;
        push(7'h04, 1, 0, 0, 1); drain_all();
        bus.stop = 1'b0;
        push(7'h00, 0, 0, 0, 3); drain_all();

        // start and stop together in IDLE: stay idle
        bus.start = 1'b1; bus.stop = 1'b1;
        push(7'h00, 0, 0, 0, 3); drain_all();
        bus.start = 1'b0; bus.stop = 1'b0;
        push(7'h00, 0, 0, 0, 1); drain_all();

        // Live write, tempo change and start while busy during playback
        wr(0, 3'd1); wr(1, 3'd3);
        bus.tempo = 8'd1; bus.len = 4'd1; bus.loop_en = 1'b1;
        pulse_start();
        push(7'h01, 1, 0, 0, 8); push(7'h00, 1, 0, 0, 4); push(7'h04, 1, 0, 1, 2);
        drain_all();
        bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 3'd5;
        bus.tempo = 8'd9; bus.start = 1'b1;
        push(7'h04, 1, 0, 1, 1); drain_all();
        bus.wr_en = 1'b0; bus.start = 1'b0;
        push(7'h04, 1, 0, 1, 5); push(7'h00, 1, 0, 1, 4);
        push(7'h01, 1, 0, 0, 8); push(7'h00, 1, 0, 0, 3);
        drain_all();
        // Rewrite step 1 on the very edge it is entered: old code 5 still plays
        bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 3'd6;
        push(7'h00, 1, 0, 0, 1); drain_all();
        bus.wr_en = 1'b0;
        push(7'h10, 1, 0, 1, 8); push(7'h00, 1, 0, 1, 4);
        push(7'h01, 1, 0, 0, 8); push(7'h00, 1, 0, 0, 4);
        push(7'h20, 1, 0, 1, 2);
        drain_all();
        bus.stop = 1'b1;
        push(7'h20, 1, 0, 1, 1); drain_all();
        bus.stop = 1'b0;
        push(7'h00, 0, 0, 0, 2); drain_all();

        // len=0, tempo=0: single step then done
        bus.tempo = 8'd0; bus.len = 4'd0; bus.loop_en = 1'b0;
        pulse_start();
        push(7'h01, 1, 0, 0, 4); push(7'h00, 1, 0, 0, 4);
        push(7'h00, 0, 1, 0, 1); push(7'h00, 0, 0, 0, 1);
        drain_all();

        // Reset mid-note clears outputs and memory
        bus.len = 4'd1;
        pulse_start();
        push(7'h01, 1, 0, 0, 3); drain_all();
        rst = 1'b1;
        push(7'h01, 1, 0, 0, 1); drain_all();
        push(7'h00, 0, 0, 0, 1); drain_all();
        rst = 1'b0;
        pulse_start();
        push(7'h00, 1, 0, 0, 8); push(7'h00, 1, 0, 1, 8);
        push(7'h00, 0, 1, 0, 1); push(7'h00, 0, 0, 0, 1);
        drain_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
